// File: rtl/cpu_pipe_pkg.sv
// Shared definitions for the CPU pipeline stage registers.
// Holds the stage occupancy state encoding and the matching occupancy counts.
package cpu_pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } pipe_state_t;

  localparam logic [1:0] OCC_EMPTY = 2'd0;
  localparam logic [1:0] OCC_ONE   = 2'd1;
  localparam logic [1:0] OCC_TWO   = 2'd2;

  function automatic logic [1:0] occ_of(input pipe_state_t s);
    case (s)
      BUSY:    occ_of = OCC_ONE;
      FULL:    occ_of = OCC_TWO;
      default: occ_of = OCC_EMPTY;
    endcase
  endfunction

endpackage

// File: rtl/pipe_skid_reg.sv
// Pipeline stage register with valid/ready handshake and a one-entry skid buffer.
// All handshake outputs are registered; out_data comes straight from the main register.
module pipe_skid_reg
  import cpu_pipe_pkg::*;
#(
  parameter int               WIDTH      = 32,
  parameter logic [WIDTH-1:0] RESET_DATA = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy
);

  pipe_state_t      state, state_nxt;
  logic [WIDTH-1:0] skid;
  logic             in_fire, out_fire;
  logic             load_main_in, load_main_skid, load_skid;

  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;

  // NOTE: every variable gets a default before the case, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    state_nxt      = state;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    case (state)
      EMPTY: begin
        if (in_fire) begin
          load_main_in = 1'b1;
          state_nxt    = BUSY;
        end
      end
      BUSY: begin
        if (in_fire && out_fire) begin
          load_main_in = 1'b1;
        end else if (in_fire) begin
          load_skid = 1'b1;
          state_nxt = FULL;
        end else if (out_fire) begin
          state_nxt = EMPTY;
        end
      end
      FULL: begin
        if (out_fire) begin
          load_main_skid = 1'b1;
          state_nxt      = BUSY;
        end
      end
      default: state_nxt = EMPTY;
    endcase
    // A flushed stage drops everything, including a word offered this cycle.
    if (flush) begin
      state_nxt      = EMPTY;
      load_main_in   = 1'b0;
      load_main_skid = 1'b0;
      load_skid      = 1'b0;
    end
  end

  // NOTE: the payload registers are reset too, because out_data must show RESET_DATA right after reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= EMPTY;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
      occupancy <= OCC_EMPTY;
      out_data  <= RESET_DATA;
      skid      <= RESET_DATA;
    end else begin
      state     <= state_nxt;
      out_valid <= (state_nxt != EMPTY);
      in_ready  <= (state_nxt != FULL);
      occupancy <= occ_of(state_nxt);
      if (load_main_in) begin
        out_data <= in_data;
      end else if (load_main_skid) begin
        out_data <= skid;
      end
      if (load_skid) begin
        skid <= in_data;
      end
    end
  end

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Self-checking bench for pipe_skid_reg: directed scenarios plus a random handshake run
// on 8-bit and 64-bit instances, compared against a queue-based reference model.
module tb_pipe_skid_reg;

  localparam logic [63:0] RST64 = 64'hDEAD_BEEF_0123_4567;
  localparam logic [7:0]  RST8  = 8'h5A;

  logic        clk = 1'b0;
  logic        rst_n, flush;
  logic        iv64, ir64, ov64, or64;
  logic [63:0] id64, od64;
  logic [1:0]  occ64;
  logic        iv8, ir8, ov8, or8;
  logic [7:0]  id8, od8;
  logic [1:0]  occ8;

  int checks   = 0;
  int failures = 0;

  logic [63:0] q64[$];
  logic [63:0] q8[$];

  always #5 clk = ~clk;

  pipe_skid_reg #(.WIDTH(64), .RESET_DATA(RST64)) dut64 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(iv64), .in_ready(ir64), .in_data(id64),
    .out_valid(ov64), .out_ready(or64), .out_data(od64), .occupancy(occ64)
  );

  pipe_skid_reg #(.WIDTH(8), .RESET_DATA(RST8)) dut8 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(iv8), .in_ready(ir8), .in_data(id8),
    .out_valid(ov8), .out_ready(or8), .out_data(od8), .occupancy(occ8)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: each stage is a FIFO of at most two words.
  task automatic compare_model();
    int n64, n8;
    n64 = q64.size();
    n8  = q8.size();
    check("occ64", {62'b0, occ64}, 64'(n64));
    check("valid64", {63'b0, ov64}, {63'b0, n64 > 0});
    check("ready64", {63'b0, ir64}, {63'b0, n64 < 2});
    if (n64 > 0) check("data64", od64, q64[0]);
    check("occ8", {62'b0, occ8}, 64'(n8));
    check("valid8", {63'b0, ov8}, {63'b0, n8 > 0});
    check("ready8", {63'b0, ir8}, {63'b0, n8 < 2});
    if (n8 > 0) check("data8", {56'b0, od8}, q8[0]);
  endtask

  task automatic step();
    bit in64, out64, in8, out8;
    logic [63:0] d64, d8;
    in64  = iv64 && (q64.size() < 2);
    out64 = or64 && (q64.size() > 0);
    in8   = iv8 && (q8.size() < 2);
    out8  = or8 && (q8.size() > 0);
    d64   = id64;
    d8    = {56'b0, id8};
    @(posedge clk);
    if (!rst_n || flush) begin
      q64.delete();
      q8.delete();
    end else begin
      if (out64) void'(q64.pop_front());
      if (in64)  q64.push_back(d64);
      if (out8)  void'(q8.pop_front());
      if (in8)   q8.push_back(d8);
    end
    #1;
    compare_model();
  endtask

  task automatic fill_full();
    or64 = 1'b0;
    iv64 = 1'b1; id64 = 64'hA; step();
    id64 = 64'hB; step();
    iv64 = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0;
    iv64 = 1'b0; or64 = 1'b0; id64 = '0;
    iv8  = 1'b0; or8  = 1'b0; id8  = '0;

    // Reset for two edges
    step(); step();
    check("rst_occ", {62'b0, occ64}, 64'd0);
    check("rst_ready", {63'b0, ir64}, 64'd1);
    check("rst_valid", {63'b0, ov64}, 64'd0);
    check("rst_data64", od64, RST64);
    check("rst_data8", {56'b0, od8}, {56'b0, RST8});
    rst_n = 1'b1;

    // Streaming at full rate
    or64 = 1'b1;
    iv64 = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      id64 = 64'(i * 8'h11);
      step();
      check("stream_data", od64, 64'(i * 8'h11));
      check("stream_ready", {63'b0, ir64}, 64'd1);
      check("stream_occ", {62'b0, occ64}, 64'd1);
    end
    iv64 = 1'b0;
    step();
    check("stream_drain", {63'b0, ov64}, 64'd0);

    // Backpressure: absorb two words, stall, then drain in order
    fill_full();
    check("bp_ready", {63'b0, ir64}, 64'd0);
    check("bp_occ", {62'b0, occ64}, 64'd2);
    for (int i = 0; i < 5; i++) begin
      step();
      check("bp_hold", od64, 64'hA);
    end
    or64 = 1'b1;
    step();
    check("bp_second", od64, 64'hB);
    check("bp_ready_back", {63'b0, ir64}, 64'd1);
    step();
    check("bp_empty", {63'b0, ov64}, 64'd0);

    // Flush in FULL while a word is offered
    fill_full();
    flush = 1'b1; iv64 = 1'b1; id64 = 64'hC;
    step();
    flush = 1'b0; iv64 = 1'b0;
    check("flush_valid", {63'b0, ov64}, 64'd0);
    check("flush_occ", {62'b0, occ64}, 64'd0);
    check("flush_ready", {63'b0, ir64}, 64'd1);
    or64 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("flush_no_c", {63'b0, ov64}, 64'd0);
    end

    // Reset mid-stream from FULL
    fill_full();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("mrst_valid", {63'b0, ov64}, 64'd0);
    check("mrst_data", od64, RST64);
    check("mrst_ready", {63'b0, ir64}, 64'd1);

    // Random handshakes on both widths
    for (int i = 0; i < 10000; i++) begin
      iv64  = 1'($urandom_range(0, 1));
      or64  = 1'($urandom_range(0, 1));
      id64  = {$urandom, $urandom};
      iv8   = 1'($urandom_range(0, 1));
      or8   = 1'($urandom_range(0, 1));
      id8   = 8'($urandom);
      flush = ($urandom_range(0, 63) == 0);
      step();
      check("rnd_occ_max", {63'b0, occ64 > 2'd2 || occ8 > 2'd2}, 64'd0);
      check("rnd_full_ready", {63'b0, (occ64 == 2'd2 && ir64) || (occ8 == 2'd2 && ir8)}, 64'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipe_skid_reg.md
# pipe_skid_reg

Parametrised pipeline register with valid/ready handshake, a one-entry skid buffer and synchronous flush. It replaces free-running temporary latches between CPU stages (IR, MDR, A/B, ALUOut paths) when the datapath moves from multi-cycle to pipelined operation. It gives full throughput with a registered `in_ready`, one-cycle latency and a stage flush for branches and exceptions.

## Interface
Parameters:
- `WIDTH`, 32: payload width in bits.
- `RESET_DATA`, 0: value of `out_data` and the skid register after reset.

Ports:
- `clk`  in  1: single clock, rising edge.
- `rst_n`  in  1: reset, synchronous and active-low.
- `flush`  in  1: synchronous discard of all held entries.
- `in_valid`  in  1: upstream presents `in_data`.
- `in_ready`  out  1: registered; the stage can accept a word this cycle.
- `in_data`  in  WIDTH: upstream payload.
- `out_valid`  out  1: `out_data` holds a valid word.
- `out_ready`  in  1: downstream accepts the word this cycle.
- `out_data`  out  WIDTH: payload, driven directly from the main register.
- `occupancy`  out  2: number of held words, 0..2.

## Operation
- Input fire: `in_valid && in_ready`. Output fire: `out_valid && out_ready`.
- Storage: a main register drives `out_data`. A skid register holds at most one extra word.
- State machine, encoded in the shared package:
  - EMPTY: 0 words. `out_valid`=0, `in_ready`=1. On in fire, load main and go to BUSY.
  - BUSY: 1 word. `out_valid`=1, `in_ready`=1.
    - In fire and out fire: load main from `in_data`, stay in BUSY.
    - In fire only: load skid, go to FULL.
    - Out fire only: go to EMPTY. Main keeps its stale value.
    - Neither: hold.
  - FULL: 2 words. `out_valid`=1, `in_ready`=0.
    - On out fire: copy skid to main, go to BUSY.
    - Otherwise: hold.
- `occupancy` is 0, 1 or 2 for EMPTY, BUSY and FULL.
- `flush`: the next state is EMPTY regardless of the current state or handshakes. A word offered in the same cycle is discarded even though `in_ready`=1. Register contents are not cleared.
- Priority: reset > flush > handshake transitions.
- Data is never modified. The block is width-transparent for any `WIDTH` ≥ 1.
- Ordering is strict FIFO. A word in skid always leaves after the word in main.

## Timing
- All outputs are registered or decoded from state only. There is no combinational path from `in_*` to `out_*` or from `out_ready` to `in_ready`.
- Reset values, while `rst_n`=0 at a clock edge: state EMPTY, `out_valid`=0, `in_ready`=1, `occupancy`=0, `out_data`=`RESET_DATA`, skid=`RESET_DATA`.
- Latency: a word accepted at edge N appears on `out_data` with `out_valid`=1 after edge N. It can leave at edge N+1.
- Throughput: 1 word/cycle sustained while `out_ready`=1.
- Backpressure: with `out_ready`=0 from BUSY, one more word is absorbed. `in_ready` drops after that edge.
- `in_ready` rises the cycle after the out fire that leaves FULL.
- Stall in FULL: `out_data` and skid hold indefinitely.
- Reset mid-operation: all held words are lost. Behaviour is identical to power-on reset, with no extra recovery cycle.
- Flush and out fire in the same cycle: the downstream transfer counts as completed. The stage is EMPTY next cycle.

## Structure
- Shared CPU package `cpu_pipe_pkg`:
  - typedef `pipe_state_t` (EMPTY=2'd0, BUSY=2'd1, FULL=2'd2).
  - Occupancy constants `OCC_EMPTY`, `OCC_ONE`, `OCC_TWO`.
- Single module, no sub-module. The skid path is one WIDTH-bit register plus a mux into main.
- Stage instances (IF/ID, ID/EX, EX/MEM, MEM/WB) differ only by `WIDTH`.

## Test plan
- Reset then stream: `rst_n`=0 for 2 cycles, then push 0x11, 0x22, 0x33 on consecutive cycles with `out_ready`=1. Required:
  - `out_data` shows 0x11, 0x22, 0x33 on consecutive cycles.
  - `in_ready` stays 1 throughout.
  - `occupancy` stays 1.
- Backpressure: with `out_ready`=0, push 0xA, then 0xB. Required:
  - `in_ready`=0 and `occupancy`=2 after the second accept.
  - Hold 5 cycles, then raise `out_ready`.
  - Output is 0xA, then 0xB, with no loss or duplication.
- Flush in FULL: with 0xA and 0xB held, assert `flush` for one cycle while `in_valid`=1 and `in_data`=0xC. Required: next cycle `out_valid`=0, `occupancy`=0, `in_ready`=1. 0xC never appears.
- Reset mid-stream: in FULL, assert `rst_n`=0 for one edge. Required: `out_valid`=0, `out_data`=`RESET_DATA`, `in_ready`=1 immediately after.
- Random handshake: 10k cycles with random `in_valid` and `out_ready`, `WIDTH`=8 and `WIDTH`=64. Scoreboard checks:
  - In-order delivery.
  - `occupancy` ≤ 2.
  - `in_ready` never 1 while FULL.
